// File: rtl/banked_read_mux_pipe.sv
// banked_read_mux_pipe: registered bank/address read-select with a valid/ready response port.
// Define PARITY_EN to add the rsp_par even-parity output.
module banked_read_mux_pipe #(
   parameter int DW = 1,
   parameter int AW = 4,
   parameter int NBANK = 4,
   parameter logic [(NBANK<<AW)-1:0] MAP_MASK = '1,
   localparam int NCH = NBANK << AW,
   localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_addr,
   input  logic [BW-1:0]     req_bank,
   input  logic              req_sel,
   input  logic              req_gate,
   input  logic [NCH*DW-1:0] ch_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_data,
`ifdef PARITY_EN
   output logic              rsp_par,
`endif
   output logic              rsp_err
);
   typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;
   state_t state;
   logic [AW-1:0] c_addr;
   logic [BW-1:0] c_bank;
   logic c_sel, c_gate;
   logic [AW+BW-1:0] idx;
   logic bank_bad, dec_err;
   logic [DW-1:0] dec_data;
   // bank*2**AW + addr is exactly the concatenation, so it can never overflow
   assign idx = {c_bank, c_addr};
   assign bank_bad = int'(c_bank) >= NBANK;
   assign dec_err = !c_sel | (bank_bad ? 1'b1 : !MAP_MASK[idx]);
   assign dec_data = !c_gate ? '1 : dec_err ? '0 : ch_data[idx*DW +: DW];
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
`ifdef PARITY_EN
         rsp_par <= 1'b0;
`endif
         c_addr <= '0;
         c_bank <= '0;
         c_sel <= 1'b0;
         c_gate <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid && req_ready) begin
               c_addr <= req_addr;
               c_bank <= req_bank;
               c_sel <= req_sel;
               c_gate <= req_gate;
               req_ready <= 1'b0;
               state <= DECODE;
            end
            DECODE: begin
               rsp_data <= dec_data;
               rsp_err <= c_gate & dec_err;
`ifdef PARITY_EN
               rsp_par <= ^dec_data;
`endif
               rsp_valid <= 1'b1;
               state <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_banked_read_mux_pipe.sv
// tb_banked_read_mux_pipe: scoreboard bench for banked_read_mux_pipe (DW=8, channel 10 unpopulated).
module tb_banked_read_mux_pipe;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NBANK = 4;
   localparam int NCH = 64;
   localparam int BW = 2;
   localparam logic [NCH-1:0] MASK = ~(64'd1 << 10);
   typedef struct packed {
      logic [DW-1:0] d;
      logic e;
   } exp_t;
   logic CK = 0, RN = 1;
   logic req_valid = 0, req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [BW-1:0] req_bank = '0;
   logic req_sel = 0, req_gate = 0;
   logic [NCH*DW-1:0] ch_data = '0;
   logic rsp_valid, rsp_ready = 0, rsp_err;
   logic [DW-1:0] rsp_data;
`ifdef PARITY_EN
   logic rsp_par;
`endif
   int total = 0, bad = 0;
   exp_t sb[$];

   always #5 CK = ~CK;

   banked_read_mux_pipe #(.DW(DW), .AW(AW), .NBANK(NBANK), .MAP_MASK(MASK)) dut (
      .CK(CK), .RN(RN), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_bank(req_bank), .req_sel(req_sel), .req_gate(req_gate),
      .ch_data(ch_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef PARITY_EN
      .rsp_par(rsp_par),
`endif
      .rsp_err(rsp_err));

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   function automatic logic [NCH*DW-1:0] garbage();
      logic [NCH*DW-1:0] v;
      for (int i = 0; i < NCH; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   task automatic check_rsp(input string tag);
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty while response expected", tag);
         return;
      end
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== sb[0].d || rsp_err !== sb[0].e) begin
         bad++;
         $display("FAIL %s: valid=%b ready=%b data=%h err=%b, want valid=1 ready=0 data=%h err=%b",
                  tag, rsp_valid, req_ready, rsp_data, rsp_err, sb[0].d, sb[0].e);
      end
`ifdef PARITY_EN
      total++;
      if (rsp_par !== ^sb[0].d) begin
         bad++;
         $display("FAIL %s par: got %b want %b", tag, rsp_par, ^sb[0].d);
      end
`endif
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready timeout: got %b want 1", tag, req_ready);
      end
   endtask

   task automatic request(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s, input logic g,
                          input logic [DW-1:0] word, input int stall, input string tag);
      logic [NCH*DW-1:0] dd;
      int idx;
      exp_t ex;
      wait_ready(tag);
      req_valid = 1; req_addr = a; req_bank = b; req_sel = s; req_gate = g;
      ch_data = garbage();
      tick();
      req_addr = ~a; req_sel = ~s; req_gate = ~g;
      idx = int'({b, a});
      dd = garbage();
      dd[idx*DW +: DW] = word;
      ch_data = dd;
      ex.e = !s || !MASK[idx];
      ex.d = !g ? '1 : ex.e ? '0 : word;
      ex.e = g & ex.e;
      sb.push_back(ex);
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s decode: valid=%b ready=%b want 0 0", tag, rsp_valid, req_ready);
      end
      tick();
      ch_data = garbage();
      check_rsp(tag);
      for (int i = 0; i < stall; i++) begin
         tick();
         check_rsp({tag, "_stall"});
      end
      req_valid = 0;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      ex = sb.pop_front();
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== ex.d || rsp_err !== ex.e) begin
         bad++;
         $display("FAIL %s done: valid=%b ready=%b data=%h err=%b, want valid=0 ready=1 data=%h err=%b",
                  tag, rsp_valid, req_ready, rsp_data, rsp_err, ex.d, ex.e);
      end
   endtask

   task automatic test_reset();
      #2 RN = 0;
      #3;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset: valid=%b data=%h err=%b want 0 0 0", rsp_valid, rsp_data, rsp_err);
      end
      @(negedge CK);
      RN = 1;
      tick();
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_select();
      request(4'd5, 2'd2, 1, 1, 8'h01, 0, "sel_b2a5");
      request(4'd15, 2'd3, 1, 1, 8'h5c, 0, "sel_b3a15");
      request(4'd0, 2'd0, 1, 1, 8'h80, 0, "sel_b0a0");
      request(4'd11, 2'd0, 1, 1, 8'h3e, 0, "sel_b0a11");
   endtask

   task automatic test_stall();
      request(4'd5, 2'd2, 1, 1, 8'h01, 5, "stall");
   endtask

   task automatic test_err();
      request(4'd5, 2'd2, 0, 1, 8'hff, 0, "err_sel");
      request(4'd10, 2'd0, 1, 1, 8'h77, 0, "err_mask");
   endtask

   task automatic test_gate();
      request(4'd10, 2'd0, 0, 0, 8'h12, 0, "gate_err");
      request(4'd3, 2'd1, 1, 0, 8'h00, 1, "gate_ok");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++)
         request(AW'($urandom), BW'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 DW'($urandom), $urandom_range(0, 2), "b2b");
   endtask

   task automatic test_parity();
`ifdef PARITY_EN
      request(4'd1, 2'd1, 1, 1, 8'ha5, 0, "par_a5");
      request(4'd2, 2'd1, 1, 1, 8'ha4, 1, "par_a4");
      total++;
      if (rsp_par !== 1'b1) begin
         bad++;
         $display("FAIL par_a4_hold: got %b want 1", rsp_par);
      end
`endif
   endtask

   task automatic test_reset_mid();
      wait_ready("rst_mid");
      req_valid = 1; req_addr = 4'd5; req_bank = 2'd2; req_sel = 1; req_gate = 1;
      tick();
      req_valid = 0;
      tick();
      #1 RN = 0;
      #1;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp: valid=%b data=%h err=%b want 0 0 0", rsp_valid, rsp_data, rsp_err);
      end
      @(negedge CK);
      RN = 1;
      tick();
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_resp_release: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
      end
      req_valid = 1;
      tick();
      req_valid = 0;
      #1 RN = 0;
      @(negedge CK);
      RN = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_decode: valid=%b ready=%b want 0 1", rsp_valid, req_ready);
         end
      end
      request(4'd9, 2'd1, 1, 1, 8'h6d, 0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_select();
      test_stall();
      test_err();
      test_gate();
      test_parity();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
